alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares a single instance of the existing ALU between two requesters, for example the execute stage and a debug/test port. Each requester uses a valid/ready handshake to submit an operation. A round-robin FSM grants one request, registers its operands, evaluates it on the ALU and returns the registered result with a requester ID. The result holds until the consumer accepts it.

## Interface
- WIDTH, 32, operand/result width
- CNT_W, 16, width of per-requester grant counters
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- REQ0_VALID / REQ1_VALID  in  1  requester has an operation pending
- REQ0_READY / REQ1_READY  out  1  operation accepted this cycle
- REQ0_A, REQ0_B / REQ1_A, REQ1_B  in  WIDTH  operands
- REQ0_FUN / REQ1_FUN  in  4  ALU function code
- RSP_VALID  out  1  result available
- RSP_READY  in  1  consumer accepts result
- RSP_ID  out  1  requester that issued the result
- RSP_DATA  out  WIDTH  ALU result
- GNT_CNT0 / GNT_CNT1  out  CNT_W  saturating accepted-operation counts
- BUSY  out  1  FSM not in IDLE

## Operation
- Function codes are passed to the ALU unchanged:
  - ADD 0000, SUB 1000, OR 0110, AND 0111, XOR 0100
  - SLL 0001, SRL 0101, SRA 1101, SLT 0010, SLTU 0011, LUI 1001 (result = B)
  - Undefined codes produce whatever the ALU produces; there is no error flag.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any REQx_VALID is high, the grant is chosen round-robin and REQx_READY for the granted requester goes high combinationally.
  - At the edge, A/B/FUN/ID are captured into operand registers, the winner's GNT_CNT increments (saturating at all-ones), and the FSM goes to EXEC.
  - If no request is valid, the FSM stays in IDLE.
- Round-robin:
  - A LAST register holds the most recently granted ID; reset value 1, so REQ0 wins the first tie.
  - If both requests are valid, the grant goes to !LAST.
  - If only one is valid, that one is granted regardless of LAST.
  - LAST updates on every grant.
- EXEC: the ALU is fed from the operand registers. At the edge, ALU_OUT is captured into RSP_DATA, RSP_ID is set from the captured ID, RSP_VALID is set to 1, and the FSM goes to RESP.
- RESP: RSP_VALID, RSP_ID and RSP_DATA are held stable. When RSP_READY is high at the edge, RSP_VALID clears and the FSM goes to IDLE. Both REQx_READY are 0 in EXEC and RESP.
- A requester must hold VALID and its operands stable until READY. The arbiter never grants a requester whose VALID is low.
- Reset (async, at any time, including mid-operation):
  - state = IDLE, LAST = 1, RSP_VALID = 0, RSP_ID = 0, RSP_DATA = 0, GNT_CNT0/1 = 0
  - The in-flight operation is dropped.
  - REQx_READY = 0 while RST_N is low.
- BUSY = (state != IDLE).

## Timing
- Accept at edge N (VALID & READY). EXEC occupies cycle N..N+1. RSP_VALID is high after edge N+1.
- Minimum issue interval is 3 cycles: accept, exec, response accepted. A new grant can occur in the cycle after the edge where the response is accepted.
- REQx_READY depends combinationally on the state, LAST, and both VALIDs. There is no combinational path from RSP_READY to REQx_READY.
- The ALU path is a single cycle, operand register to result register, with no multicycle exceptions.
- Counter saturation: at all-ones, a further grant leaves the value unchanged.

## Structure
- Package alu_pkg:
  - localparams for all 11 function codes
  - typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t
  - typedef struct for a request (a, b, fun)
- Sub-module: one instance of the existing ALU (ports A, B, ALU_FUN, ALU_OUT). Arbitration, FSM and counters are inline.

## Test plan
- Single request: REQ0 ADD A=0xAA, B=0xAA with RSP_READY=1 -> REQ0_READY high for 1 cycle; RSP_VALID 2 edges later; RSP_DATA=0x154, RSP_ID=0; GNT_CNT0=1.
- Simultaneous requests after reset: REQ0 SUB 0xC8-0x37 and REQ1 XOR 0xAAAABBBB^0xFFFFFFFF -> first response ID0 = 0x91, then ID1 = 0x55554444; REQ1 waits with VALID held.
- Fairness: both VALID continuously for 6 ops (REQ0 SLL 0xAA<<0x0C, REQ1 SLTU 0xAA,0x55) -> IDs alternate 0,1,0,1,0,1; data 0xAA000 / 0x0; both counters = 3.
- Backpressure: REQ1 SRA A=-20, B=2 with RSP_READY low for 5 cycles -> RSP_VALID and RSP_DATA=0xFFFFFFFB stable throughout; REQx_READY stay 0; one cycle after RSP_READY rises, the FSM is back in IDLE.
- LUI and SLT: REQ0 LUI B=0x12345678 -> 0x12345678; REQ0 SLT A=-5, B=-10 -> 0x0.
- Reset mid-operation: assert RST_N low during EXEC -> RSP_VALID, BUSY and counters go to 0 immediately; after release, a tied request grants REQ0 first.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and the two-requester ALU arbiter.
//   - ALU_W       : native datapath width of the shared ALU
//   - FUN_*       : 4-bit ALU function codes
//   - arb_state_t : arbiter FSM states
//   - alu_req_t   : one captured request (operands + function)
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] FUN_ADD  = 4'b0000;
  localparam logic [3:0] FUN_SUB  = 4'b1000;
  localparam logic [3:0] FUN_OR   = 4'b0110;
  localparam logic [3:0] FUN_AND  = 4'b0111;
  localparam logic [3:0] FUN_XOR  = 4'b0100;
  localparam logic [3:0] FUN_SLL  = 4'b0001;
  localparam logic [3:0] FUN_SRL  = 4'b0101;
  localparam logic [3:0] FUN_SRA  = 4'b1101;
  localparam logic [3:0] FUN_SLT  = 4'b0010;
  localparam logic [3:0] FUN_SLTU = 4'b0011;
  localparam logic [3:0] FUN_LUI  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [3:0]       fun;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// alu: single-cycle combinational ALU shared by the arbiter.
// Ports:
//   A, B    : operands
//   ALU_FUN : function code (alu_pkg::FUN_*)
//   ALU_OUT : result; undefined codes give 0
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic [WIDTH-1:0] ALU_OUT
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] w_shamt;
  assign w_shamt = B[SH_W-1:0];

  always_comb begin
    ALU_OUT = '0;
    case (ALU_FUN)
      FUN_ADD:  ALU_OUT = A + B;
      FUN_SUB:  ALU_OUT = A - B;
      FUN_OR:   ALU_OUT = A | B;
      FUN_AND:  ALU_OUT = A & B;
      FUN_XOR:  ALU_OUT = A ^ B;
      FUN_SLL:  ALU_OUT = A << w_shamt;
      FUN_SRL:  ALU_OUT = A >> w_shamt;
      FUN_SRA:  ALU_OUT = $unsigned($signed(A) >>> w_shamt);
      FUN_SLT:  ALU_OUT = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      FUN_SLTU: ALU_OUT = {{(WIDTH-1){1'b0}}, (A < B)};
      FUN_LUI:  ALU_OUT = B;
      default:  ALU_OUT = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two valid/ready requesters.
// Ports:
//   CLK, RST_N               : clock, async active-low reset
//   REQx_VALID/READY         : request handshake, x = 0/1
//   REQx_A/B/FUN             : request operands and function code
//   RSP_VALID/READY/ID/DATA  : registered response, held until accepted
//   GNT_CNT0/1               : saturating accepted-operation counters
//   BUSY                     : FSM not in IDLE
//   DBG_STATE                : current FSM state
//
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both high. Requesters hold VALID and operands until READY; READY is only
// raised in IDLE, never depends on RSP_READY, and is low while in reset.
// The response side holds RSP_VALID/ID/DATA until RSP_READY at an edge.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic [3:0]       REQ0_FUN,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic [3:0]       REQ1_FUN,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_ID,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic [CNT_W-1:0] GNT_CNT0,
  output logic [CNT_W-1:0] GNT_CNT1,
  output logic             BUSY,
  output arb_state_t       DBG_STATE
);

  arb_state_t       r_state;
  logic             r_last;
  alu_req_t         r_op;
  logic             r_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_gnt_any;
  logic             w_gnt_id;
  alu_req_t         w_sel;
  logic [WIDTH-1:0] w_alu_out;

  // Tie goes to the requester not served last; a lone request always wins.
  assign w_gnt_any = RST_N && (r_state == IDLE) && (REQ0_VALID || REQ1_VALID);
  assign w_gnt_id  = (REQ0_VALID && REQ1_VALID) ? ~r_last : REQ1_VALID;

  assign REQ0_READY = w_gnt_any && !w_gnt_id;
  assign REQ1_READY = w_gnt_any &&  w_gnt_id;

  always_comb begin
    w_sel = '0;
    if (w_gnt_id) begin
      w_sel.a   = REQ1_A;
      w_sel.b   = REQ1_B;
      w_sel.fun = REQ1_FUN;
    end else begin
      w_sel.a   = REQ0_A;
      w_sel.b   = REQ0_B;
      w_sel.fun = REQ0_FUN;
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .A       (r_op.a),
    .B       (r_op.b),
    .ALU_FUN (r_op.fun),
    .ALU_OUT (w_alu_out)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_op        <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_op    <= w_sel;
            r_id    <= w_gnt_id;
            r_last  <= w_gnt_id;
            r_state <= EXEC;
            if (!w_gnt_id && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if ( w_gnt_id && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + CNT_W'(1);
          end
        end
        EXEC: begin
          r_rsp_data  <= w_alu_out;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign RSP_VALID = r_rsp_valid;
  assign RSP_ID    = r_rsp_id;
  assign RSP_DATA  = r_rsp_data;
  assign GNT_CNT0  = r_cnt0;
  assign GNT_CNT1  = r_cnt1;
  assign BUSY      = (r_state != IDLE);
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, self-checking bench for alu_arbiter.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 3;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             REQ0_VALID, REQ1_VALID;
  logic             REQ0_READY, REQ1_READY;
  logic [WIDTH-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [3:0]       REQ0_FUN, REQ1_FUN;
  logic             RSP_VALID, RSP_READY, RSP_ID;
  logic [WIDTH-1:0] RSP_DATA;
  logic [CNT_W-1:0] GNT_CNT0, GNT_CNT1;
  logic             BUSY;
  arb_state_t       DBG_STATE;

  int n_assert = 0;
  int n_fail   = 0;

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .REQ0_VALID (REQ0_VALID),
    .REQ0_READY (REQ0_READY),
    .REQ0_A     (REQ0_A),
    .REQ0_B     (REQ0_B),
    .REQ0_FUN   (REQ0_FUN),
    .REQ1_VALID (REQ1_VALID),
    .REQ1_READY (REQ1_READY),
    .REQ1_A     (REQ1_A),
    .REQ1_B     (REQ1_B),
    .REQ1_FUN   (REQ1_FUN),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_ID     (RSP_ID),
    .RSP_DATA   (RSP_DATA),
    .GNT_CNT0   (GNT_CNT0),
    .GNT_CNT1   (GNT_CNT1),
    .BUSY       (BUSY),
    .DBG_STATE  (DBG_STATE)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Helpers
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    #1;
  endtask

  // Drive one request and hold it until accepted, then drop VALID.
  task automatic issue(input string tag, input logic id, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] fun);
    logic rdy;
    if (id) begin
      REQ1_A = a; REQ1_B = b; REQ1_FUN = fun; REQ1_VALID = 1'b1;
    end else begin
      REQ0_A = a; REQ0_B = b; REQ0_FUN = fun; REQ0_VALID = 1'b1;
    end
    #1;
    for (int i = 0; i < 8; i++) begin
      rdy = id ? REQ1_READY : REQ0_READY;
      if (rdy) break;
      step();
    end
    rdy = id ? REQ1_READY : REQ0_READY;
    chk({tag, "_ready"}, rdy, 1'b1);
    step();
    if (id) REQ1_VALID = 1'b0;
    else    REQ0_VALID = 1'b0;
    #1;
  endtask

  // Wait (bounded) for a response, check it, then let one edge pass.
  task automatic expect_rsp(input string tag, input logic id, input logic [31:0] data);
    for (int i = 0; i < 8 && !RSP_VALID; i++) step();
    chk({tag, "_valid"}, RSP_VALID, 1'b1);
    chk({tag, "_id"},    RSP_ID,    id);
    chk({tag, "_data"},  RSP_DATA,  data);
    step();
  endtask

  initial begin
    RST_N = 1'b0;
    RSP_READY = 1'b0;
    REQ0_VALID = 1'b1; REQ0_A = '0; REQ0_B = '0; REQ0_FUN = FUN_ADD;
    REQ1_VALID = 1'b0; REQ1_A = '0; REQ1_B = '0; REQ1_FUN = FUN_ADD;
    step();
    step();

    // Reset state; REQ0 valid but READY must stay low in reset
    chk("rst_rsp_valid", RSP_VALID, 1'b0);
    chk("rst_rsp_id",    RSP_ID,    1'b0);
    chk("rst_rsp_data",  RSP_DATA,  32'h0);
    chk("rst_busy",      BUSY,      1'b0);
    chk("rst_state",     DBG_STATE, IDLE);
    chk("rst_cnt0",      GNT_CNT0,  3'd0);
    chk("rst_cnt1",      GNT_CNT1,  3'd0);
    chk("rst_ready0",    REQ0_READY, 1'b0);
    REQ0_VALID = 1'b0;
    RST_N = 1'b1;
    step();

    // Single request: ADD 0xAA + 0xAA
    REQ0_A = 32'hAA; REQ0_B = 32'hAA; REQ0_FUN = FUN_ADD; REQ0_VALID = 1'b1;
    RSP_READY = 1'b1;
    #1;
    chk("single_ready0", REQ0_READY, 1'b1);
    chk("single_ready1", REQ1_READY, 1'b0);
    step();
    REQ0_VALID = 1'b0;
    #1;
    chk("single_busy",   BUSY,       1'b1);
    chk("single_exec",   DBG_STATE,  EXEC);
    chk("single_ready0_exec", REQ0_READY, 1'b0);
    chk("single_nrsp",   RSP_VALID,  1'b0);
    step();
    chk("single_valid",  RSP_VALID,  1'b1);
    chk("single_data",   RSP_DATA,   32'h154);
    chk("single_id",     RSP_ID,     1'b0);
    chk("single_cnt0",   GNT_CNT0,   3'd1);
    step();
    chk("single_done_valid", RSP_VALID, 1'b0);
    chk("single_done_busy",  BUSY,      1'b0);

    // Simultaneous requests after reset: REQ0 wins the first tie
    reset_dut();
    REQ0_A = 32'hC8; REQ0_B = 32'h37; REQ0_FUN = FUN_SUB; REQ0_VALID = 1'b1;
    REQ1_A = 32'hAAAABBBB; REQ1_B = 32'hFFFFFFFF; REQ1_FUN = FUN_XOR; REQ1_VALID = 1'b1;
    #1;
    chk("tie_ready0", REQ0_READY, 1'b1);
    chk("tie_ready1", REQ1_READY, 1'b0);
    step();
    REQ0_VALID = 1'b0;
    #1;
    chk("tie_ready1_exec", REQ1_READY, 1'b0);
    expect_rsp("tie_rsp0", 1'b0, 32'h91);
    chk("tie_ready1_idle", REQ1_READY, 1'b1);
    step();
    REQ1_VALID = 1'b0;
    #1;
    expect_rsp("tie_rsp1", 1'b1, 32'h55554444);

    // Fairness: both VALID held for 6 operations
    reset_dut();
    REQ0_A = 32'hAA; REQ0_B = 32'h0C; REQ0_FUN = FUN_SLL;  REQ0_VALID = 1'b1;
    REQ1_A = 32'hAA; REQ1_B = 32'h55; REQ1_FUN = FUN_SLTU; REQ1_VALID = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      expect_rsp("fair", k[0], k[0] ? 32'h0 : 32'hAA000);
    end
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    #1;
    chk("fair_cnt0", GNT_CNT0, 3'd3);
    chk("fair_cnt1", GNT_CNT1, 3'd3);

    // Backpressure: SRA -20 >>> 2, response held 5 cycles
    RSP_READY = 1'b0;
    issue("bp", 1'b1, 32'hFFFFFFEC, 32'd2, FUN_SRA);
    for (int i = 0; i < 8 && !RSP_VALID; i++) step();
    REQ0_A = 32'd1; REQ0_B = 32'd1; REQ0_FUN = FUN_ADD;
    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",  RSP_VALID,  1'b1);
      chk("bp_data",   RSP_DATA,   32'hFFFFFFFB);
      chk("bp_id",     RSP_ID,     1'b1);
      chk("bp_ready0", REQ0_READY, 1'b0);
      chk("bp_ready1", REQ1_READY, 1'b0);
      step();
    end
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    RSP_READY  = 1'b1;
    #1;
    step();
    chk("bp_state_idle", DBG_STATE, IDLE);
    chk("bp_busy",       BUSY,      1'b0);
    chk("bp_rsp_clear",  RSP_VALID, 1'b0);
    chk("bp_cnt1",       GNT_CNT1,  3'd4);

    // LUI and SLT
    issue("lui", 1'b0, 32'hDEAD, 32'h12345678, FUN_LUI);
    expect_rsp("lui", 1'b0, 32'h12345678);
    issue("slt_a", 1'b0, 32'hFFFFFFFB, 32'hFFFFFFF6, FUN_SLT);
    expect_rsp("slt_a", 1'b0, 32'h0);
    issue("slt_b", 1'b0, 32'hFFFFFFF6, 32'hFFFFFFFB, FUN_SLT);
    expect_rsp("slt_b", 1'b0, 32'h1);
    chk("pre_sat_cnt0", GNT_CNT0, 3'd6);

    // Counter saturation (CNT_W = 3): 3 more grants stop at 7
    for (int i = 0; i < 3; i++) begin
      issue("sat", 1'b0, 32'd5, 32'd3, FUN_OR);
      expect_rsp("sat", 1'b0, 32'd7);
    end
    chk("sat_cnt0", GNT_CNT0, 3'd7);
    chk("sat_cnt1", GNT_CNT1, 3'd4);

    // Reset mid-operation
    REQ0_A = 32'd1; REQ0_B = 32'd2; REQ0_FUN = FUN_ADD; REQ0_VALID = 1'b1;
    REQ1_A = 32'hF0; REQ1_B = 32'h3C; REQ1_FUN = FUN_AND; REQ1_VALID = 1'b1;
    #1;
    step();
    chk("mid_exec", DBG_STATE, EXEC);
    RST_N = 1'b0;
    #1;
    chk("mid_rsp_valid", RSP_VALID,  1'b0);
    chk("mid_busy",      BUSY,       1'b0);
    chk("mid_cnt0",      GNT_CNT0,   3'd0);
    chk("mid_cnt1",      GNT_CNT1,   3'd0);
    chk("mid_ready0",    REQ0_READY, 1'b0);
    chk("mid_ready1",    REQ1_READY, 1'b0);
    step();
    RST_N = 1'b1;
    #1;
    chk("post_ready0", REQ0_READY, 1'b1);
    chk("post_ready1", REQ1_READY, 1'b0);
    step();
    REQ0_VALID = 1'b0;
    #1;
    expect_rsp("post_rsp0", 1'b0, 32'd3);
    chk("post_ready1_idle", REQ1_READY, 1'b1);
    step();
    REQ1_VALID = 1'b0;
    #1;
    expect_rsp("post_rsp1", 1'b1, 32'h30);
    chk("post_cnt0", GNT_CNT0, 3'd1);
    chk("post_cnt1", GNT_CNT1, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
